branch_annul_controller: RTL and testbench
==========================================

Name: branch_annul_controller

Overview:
- Sequences the SPARC pipeline front end around reset release and delayed control-transfer instructions (DCTIs).
- Stretches system reset into a pipeline-wide reset of fixed length.
- Resolves each ID-stage branch into a PC-source select and a delay-slot annul (IF/ID flush) per SPARC annul-bit rules.
- Sits between the reset logic / ID-stage decode and the PC mux / IF-ID pipeline register.

Parameters:
- RESET_CYCLES, 4, cycles pipeline_reset_out stays high after system_reset deasserts; legal range >=1.
- CNT_W, 8, width of the saturating annul event counter.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- system_reset  in  1  synchronous, active-low reset (0 = reset).
- ID_branch_instr  in  1  ID stage holds a Bicc DCTI.
- a  in  1  annul bit of the ID-stage branch.
- cond_true  in  1  branch condition evaluated true this cycle.
- branch_always  in  1  ID-stage branch is BA (unconditional).
- stall  in  1  pipeline stall; freezes controller decisions.
- pipeline_reset_out  out  1  active-high reset to pipeline registers.
- pc_src  out  1  1 = select branch target for next fetch.
- IF_ID_flush  out  1  clears IF/ID register (annuls delay slot).
- annul_count  out  CNT_W  number of annulled delay slots, saturating.

Behaviour:
- All outputs are registered or decoded from registered state; no combinational input-to-output path.
- Reset is synchronous. On any edge with system_reset=0:
  - state<=S_RST, rcnt<=0, taken_q<=0, annul_q<=0, annul_count<=0.
  - Outputs after that edge: pipeline_reset_out=1, pc_src=0, IF_ID_flush=0, annul_count=0.
- Reset has priority over every other input and aborts S_SLOT mid-operation. A pending pc_src/flush is discarded.
- FSM states:
  - S_RST: pipeline_reset_out=1. Branch inputs and stall are ignored. Each edge with system_reset=1 does rcnt++. At the edge where rcnt==RESET_CYCLES-1, go to S_RUN. pipeline_reset_out is therefore high for exactly RESET_CYCLES cycles after the first edge sampling system_reset=1.
  - S_RUN: pipeline_reset_out=0, pc_src=0, IF_ID_flush=0.
    - Edge with ID_branch_instr=1 and stall=0: taken = cond_true | branch_always; taken_q<=taken; annul_q<=a & (~taken | branch_always); go to S_SLOT.
    - stall=1: stay in S_RUN; the branch is re-sampled when the stall clears.
  - S_SLOT (delay slot in IF/ID): pc_src=taken_q, IF_ID_flush=annul_q.
    - stall=1: hold state and outputs unchanged.
    - stall=0: next edge returns to S_RUN; if annul_q=1, annul_count increments, saturating at 2^CNT_W-1.
    - ID_branch_instr while in S_SLOT (DCTI couple) is ignored.
- Annul truth table (branch, stall=0):
  - taken, a=0 → slot executes.
  - taken non-BA, a=1 → slot executes.
  - BA, a=1 → slot annulled.
  - not taken, a=1 → slot annulled.
  - not taken, a=0 → slot executes.
- Branch latency: decision visible on pc_src/IF_ID_flush exactly one cycle after the sampling edge, lasting 1 cycle plus any stall cycles.
- Back-to-back branches: the earliest next branch sampling is the edge after the one leaving S_SLOT.

Test Plan:
- Reset stretch: hold system_reset=0 for 3 edges, release, RESET_CYCLES=4 → pipeline_reset_out=1 for 4 cycles after release, then 0; pc_src=0, IF_ID_flush=0, annul_count=0 throughout.
- Annul truth table in S_RUN, one branch per case:
  - cond_true=1,a=0 → pc_src=1, IF_ID_flush=0.
  - cond_true=0,a=1 → pc_src=0, IF_ID_flush=1.
  - branch_always=1,a=1 → pc_src=1, IF_ID_flush=1.
  - cond_true=0,a=0 → both 0.
  - annul_count ends at 2.
- Stall: branch with cond_true=0,a=1, then stall=1 for 3 cycles in S_SLOT → IF_ID_flush held 1 for 4 cycles; annul_count increments once. Separately, branch presented with stall=1 in S_RUN produces no outputs until the stall drops.
- Reset mid-operation: system_reset=0 while in S_SLOT with annul_q=1 → next cycle IF_ID_flush=0, pc_src=0, pipeline_reset_out=1, annul_count=0.
- Saturation: CNT_W=2, 5 annulling branches → annul_count reaches 3 and stays 3.
- DCTI couple and reset gating: ID_branch_instr=1 held across S_SLOT → only one decision per 2 cycles; branch inputs during S_RST → no pc_src/IF_ID_flush activity.

Source files
------------

// File: rtl/branch_annul_controller.sv
// branch_annul_controller: stretches system reset into a fixed-length
// pipeline reset and resolves ID-stage Bicc DCTIs into a PC-source select
// and a delay-slot annul (IF/ID flush) following SPARC annul-bit rules.
//
// Ports:
//   clk                 system clock, all state on rising edge
//   system_reset        synchronous active-low reset (0 = reset)
//   ID_branch_instr     ID stage holds a Bicc DCTI
//   a                   annul bit of the ID-stage branch
//   cond_true           branch condition true this cycle
//   branch_always       ID-stage branch is BA
//   stall               pipeline stall, freezes decisions
//   pipeline_reset_out  active-high reset to pipeline registers
//   pc_src              1 = fetch from branch target
//   IF_ID_flush         clear IF/ID (annul delay slot)
//   annul_count         saturating count of annulled delay slots
module branch_annul_controller #(
    parameter int RESET_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             system_reset,
    input  logic             ID_branch_instr,
    input  logic             a,
    input  logic             cond_true,
    input  logic             branch_always,
    input  logic             stall,
    output logic             pipeline_reset_out,
    output logic             pc_src,
    output logic             IF_ID_flush,
    output logic [CNT_W-1:0] annul_count
);

    localparam int RCNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_RUN  = 2'd1,
        S_SLOT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
    logic               taken_q, taken_d;
    logic               annul_q, annul_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               taken_w;

    assign taken_w = cond_true | branch_always;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        taken_d = taken_q;
        annul_d = annul_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_RST: begin
                if (rcnt_q == RCNT_LAST) begin
                    state_d = S_RUN;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (ID_branch_instr && !stall) begin
                    taken_d = taken_w;
                    // BA,a=1 annuls even though taken; other taken
                    // branches execute the slot.
                    annul_d = a & (~taken_w | branch_always);
                    state_d = S_SLOT;
                end
            end
            S_SLOT: begin
                if (!stall) begin
                    state_d = S_RUN;
                    if (annul_q && (cnt_q != {CNT_W{1'b1}})) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!system_reset) begin
            state_q <= S_RST;
            rcnt_q  <= '0;
            taken_q <= 1'b0;
            annul_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            taken_q <= taken_d;
            annul_q <= annul_d;
            cnt_q   <= cnt_d;
        end
    end

    // Decisions are only visible while the delay slot sits in IF/ID.
    assign pipeline_reset_out = (state_q == S_RST);
    assign pc_src             = (state_q == S_SLOT) & taken_q;
    assign IF_ID_flush        = (state_q == S_SLOT) & annul_q;
    assign annul_count        = cnt_q;

endmodule

// File: tb/tb_branch_annul_controller.sv
// Directed self-checking bench for branch_annul_controller: reset stretch,
// annul truth table, stalls, mid-slot reset, DCTI couple, counter saturation.
module tb_branch_annul_controller;

    logic       clk = 1'b0;
    logic       system_reset;
    logic       ID_branch_instr;
    logic       a;
    logic       cond_true;
    logic       branch_always;
    logic       stall;
    logic       pro, pc, fl;
    logic [7:0] cnt;
    logic       pro2, pc2, fl2;
    logic [1:0] cnt2;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    branch_annul_controller #(.RESET_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .system_reset(system_reset),
        .ID_branch_instr(ID_branch_instr), .a(a),
        .cond_true(cond_true), .branch_always(branch_always),
        .stall(stall), .pipeline_reset_out(pro), .pc_src(pc),
        .IF_ID_flush(fl), .annul_count(cnt)
    );

    branch_annul_controller #(.RESET_CYCLES(4), .CNT_W(2)) dut2 (
        .clk(clk), .system_reset(system_reset),
        .ID_branch_instr(ID_branch_instr), .a(a),
        .cond_true(cond_true), .branch_always(branch_always),
        .stall(stall), .pipeline_reset_out(pro2), .pc_src(pc2),
        .IF_ID_flush(fl2), .annul_count(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic outs(input string tag, input logic e_pro,
                        input logic e_pc, input logic e_fl,
                        input logic [7:0] e_cnt);
        chk({tag, ".pro"}, 32'(pro), 32'(e_pro));
        chk({tag, ".pc"},  32'(pc),  32'(e_pc));
        chk({tag, ".fl"},  32'(fl),  32'(e_fl));
        chk({tag, ".cnt"}, 32'(cnt), 32'(e_cnt));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic c, input logic ba, input logic an);
        ID_branch_instr = 1'b1;
        cond_true       = c;
        branch_always   = ba;
        a               = an;
    endtask

    task automatic idle();
        ID_branch_instr = 1'b0;
        cond_true       = 1'b0;
        branch_always   = 1'b0;
        a               = 1'b0;
    endtask

    initial begin
        system_reset = 1'b0;
        stall        = 1'b0;
        idle();

        // reset held low 3 edges, branch inputs active meanwhile
        br(1'b1, 1'b1, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            outs("rst_hold", 1'b1, 1'b0, 1'b0, 8'd0);
        end
        stall = 1'b0;
        system_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            outs("rst_stretch", 1'b1, 1'b0, 1'b0, 8'd0);
        end
        cyc();
        outs("rst_done", 1'b0, 1'b0, 1'b0, 8'd0);
        idle();

        // truth table: taken a=0
        br(1'b1, 1'b0, 1'b0); cyc(); idle();
        outs("tt_taken_a0", 1'b0, 1'b1, 1'b0, 8'd0);
        cyc();
        outs("tt_taken_a0_ret", 1'b0, 1'b0, 1'b0, 8'd0);
        // not taken a=1
        br(1'b0, 1'b0, 1'b1); cyc(); idle();
        outs("tt_nt_a1", 1'b0, 1'b0, 1'b1, 8'd0);
        cyc();
        outs("tt_nt_a1_ret", 1'b0, 1'b0, 1'b0, 8'd1);
        // BA a=1
        br(1'b0, 1'b1, 1'b1); cyc(); idle();
        outs("tt_ba_a1", 1'b0, 1'b1, 1'b1, 8'd1);
        cyc();
        outs("tt_ba_a1_ret", 1'b0, 1'b0, 1'b0, 8'd2);
        // not taken a=0
        br(1'b0, 1'b0, 1'b0); cyc(); idle();
        outs("tt_nt_a0", 1'b0, 1'b0, 1'b0, 8'd2);
        cyc();
        // taken non-BA a=1
        br(1'b1, 1'b0, 1'b1); cyc(); idle();
        outs("tt_taken_a1", 1'b0, 1'b1, 1'b0, 8'd2);
        cyc();
        outs("tt_end", 1'b0, 1'b0, 1'b0, 8'd2);

        // stall in S_SLOT for 3 cycles
        br(1'b0, 1'b0, 1'b1); cyc(); idle();
        stall = 1'b1;
        outs("slot_stall0", 1'b0, 1'b0, 1'b1, 8'd2);
        for (int i = 0; i < 3; i++) begin
            cyc();
            outs("slot_stall", 1'b0, 1'b0, 1'b1, 8'd2);
        end
        stall = 1'b0;
        cyc();
        outs("slot_stall_ret", 1'b0, 1'b0, 1'b0, 8'd3);

        // branch held during stall in S_RUN
        br(1'b1, 1'b0, 1'b0);
        stall = 1'b1;
        cyc();
        outs("run_stall1", 1'b0, 1'b0, 1'b0, 8'd3);
        cyc();
        outs("run_stall2", 1'b0, 1'b0, 1'b0, 8'd3);
        stall = 1'b0;
        cyc(); idle();
        outs("run_stall_rel", 1'b0, 1'b1, 1'b0, 8'd3);
        cyc();
        outs("run_stall_ret", 1'b0, 1'b0, 1'b0, 8'd3);

        // reset while in annulling S_SLOT
        br(1'b0, 1'b0, 1'b1); cyc(); idle();
        outs("mid_slot", 1'b0, 1'b0, 1'b1, 8'd3);
        system_reset = 1'b0;
        cyc();
        outs("mid_rst", 1'b1, 1'b0, 1'b0, 8'd0);
        system_reset = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        outs("mid_rst_stretch", 1'b1, 1'b0, 1'b0, 8'd0);
        cyc();
        outs("mid_rst_done", 1'b0, 1'b0, 1'b0, 8'd0);

        // DCTI couple: branch held, one decision every 2 cycles
        br(1'b0, 1'b0, 1'b1);
        cyc();
        outs("couple_s1", 1'b0, 1'b0, 1'b1, 8'd0);
        cyc();
        outs("couple_r1", 1'b0, 1'b0, 1'b0, 8'd1);
        cyc();
        outs("couple_s2", 1'b0, 1'b0, 1'b1, 8'd1);
        cyc(); idle();
        outs("couple_r2", 1'b0, 1'b0, 1'b0, 8'd2);

        // saturation on the 2-bit counter after fresh reset
        system_reset = 1'b0;
        cyc();
        chk("sat_rst", 32'(cnt2), 32'd0);
        system_reset = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("sat_run", 32'(pro2), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            br(1'b0, 1'b0, 1'b1); cyc(); idle();
            chk("sat_flush", 32'(fl2), 32'd1);
            cyc();
            chk("sat_cnt2", 32'(cnt2), 32'((i > 3) ? 3 : i));
            chk("sat_cnt8", 32'(cnt), 32'(i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
